// File: rtl/slurm16_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : slurm16_memory_arbiter
//  Purpose  : Shares one single-port 16-bit SRAM between the CPU (port 0) and
//             up to three other bus masters. Round-robin arbitration with
//             burst ownership: the owner keeps the bus while it holds valid,
//             for at most MAX_BURST accesses per ownership.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           clock
//    rstb_i          synchronous active-low reset
//    req_valid_i     [NREQ]          request pending, held until accepted
//    req_wr_i        [NREQ]          1 = write, 0 = read
//    req_address_i   [NREQ*ADDR]     packed, requester k at [k*ADDR +: ADDR]
//    req_wdata_i     [NREQ*BITS]     packed write data
//    req_ready_o     [NREQ]          access accepted this cycle (combinational)
//    rdata_o         [BITS]          read data, pass-through of sram_rdata_i
//    rdata_valid_o   [NREQ]          rdata_o belongs to requester k this cycle
//    sram_address_o  [ADDR]          SRAM address of the current access
//    sram_wdata_o    [BITS]          SRAM write data
//    sram_wr_o                       SRAM write strobe
//    sram_rdata_i    [BITS]          SRAM read data, one cycle after address
// ============================================================================
module slurm16_memory_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                         clk_i,
  input  logic                         rstb_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ-1:0]              req_wr_i,
  input  logic [NREQ*ADDRESS_BITS-1:0] req_address_i,
  input  logic [NREQ*BITS-1:0]         req_wdata_i,
  output logic [NREQ-1:0]              req_ready_o,
  output logic [BITS-1:0]              rdata_o,
  output logic [NREQ-1:0]              rdata_valid_o,
  output logic [ADDRESS_BITS-1:0]      sram_address_o,
  output logic [BITS-1:0]              sram_wdata_o,
  output logic                         sram_wr_o,
  input  logic [BITS-1:0]              sram_rdata_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [0:0]      state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0] rdata_valid_q, rdata_valid_d;

  logic            acc;
  logic            burst_limit;
  logic [2:0]      pick_idle;
  logic [2:0]      pick_other;

  // Round-robin search starting just after 'base'. Result is {found, index}.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [2:0] pick(input logic [NREQ-1:0] valid,
                                      input logic [1:0]      base,
                                      input logic            excl,
                                      input logic [1:0]      skip);
    logic [2:0] r;
    logic [1:0] k;
    r = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      k = base + 2'(i);
      if (valid[k] && !(excl && (k == skip))) begin
        r = {1'b1, k};
      end
    end
    return r;
  endfunction

  assign acc         = (state_q == ST_OWN) && req_valid_i[owner_q];
  assign burst_limit = (burst_cnt_q == BURST_LAST);

  // A fresh grant scans from last_q; a hand-over scans from the outgoing
  // owner, which also becomes 'last', and never re-picks it.
  assign pick_idle  = pick(req_valid_i, last_q, 1'b0, owner_q);
  assign pick_other = pick(req_valid_i, owner_q, 1'b1, owner_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= 2'd0;
      last_q        <= 2'd3;
      burst_cnt_q   <= 4'd0;
      rdata_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      burst_cnt_q   <= burst_cnt_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    burst_cnt_d   = burst_cnt_q;
    rdata_valid_d = '0;

    if (acc && !req_wr_i[owner_q]) begin
      rdata_valid_d[owner_q] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d     = ST_OWN;
          owner_d     = pick_idle[1:0];
          burst_cnt_d = 4'd0;
        end
      end
      ST_OWN: begin
        if (acc) begin
          if (burst_limit) begin
            // Burst exhausted: hand over without a bubble if anyone waits,
            // otherwise the same owner starts a new burst.
            last_d      = owner_q;
            burst_cnt_d = 4'd0;
            if (pick_other[2]) begin
              owner_d = pick_other[1:0];
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else begin
          last_d      = owner_q;
          burst_cnt_d = 4'd0;
          if (pick_other[2]) begin
            owner_d = pick_other[1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o    = '0;
    sram_address_o = '0;
    sram_wdata_o   = '0;
    sram_wr_o      = 1'b0;
    if (acc) begin
      req_ready_o[owner_q] = 1'b1;
      sram_address_o       = req_address_i[owner_q*ADDRESS_BITS +: ADDRESS_BITS];
      sram_wdata_o         = req_wdata_i[owner_q*BITS +: BITS];
      sram_wr_o            = req_wr_i[owner_q];
    end
  end

  assign rdata_o       = sram_rdata_i;
  assign rdata_valid_o = rdata_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_slurm16_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slurm16_memory_arbiter
//  Purpose  : Self-checking bench for slurm16_memory_arbiter. Directed
//             scenarios plus randomized traffic compared against a
//             transaction-level round-robin model and a shadow SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slurm16_memory_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  req_valid, req_wr, req_ready, rdata_valid;
  logic [63:0] req_address, req_wdata;
  logic [15:0] rdata, sram_address, sram_wdata, sram_rdata;
  logic        sram_wr;

  always #5 clk = ~clk;

  slurm16_memory_arbiter #(
    .BITS(16), .ADDRESS_BITS(16), .NREQ(4), .MAX_BURST(MAXB)
  ) dut (
    .clk_i(clk), .rstb_i(rstb),
    .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_address_i(req_address), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rdata_o(rdata), .rdata_valid_o(rdata_valid),
    .sram_address_o(sram_address), .sram_wdata_o(sram_wdata),
    .sram_wr_o(sram_wr), .sram_rdata_i(sram_rdata)
  );

  // SRAM: synchronous read, data one cycle after address
  bit [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (sram_wr) mem[sram_address] <= sram_wdata;
    sram_rdata <= mem[sram_address];
  end

  // Requester-side stimulus
  bit        pv [4];
  bit        pw [4];
  bit [15:0] pa [4];
  bit [15:0] pd [4];

  // Reference model: owner (-1 = nobody), accesses in this ownership, last
  // owner, shadow memory and the pending read result.
  int        m_own = -1;
  int        m_cnt = 0;
  int        m_last = 3;
  bit [3:0]  m_rv = '0;
  bit [15:0] m_rdata = '0;
  bit [15:0] ref_mem [0:65535];

  logic [3:0]  e_ready, e_rv;
  logic [15:0] e_addr, e_wdata, e_rdata;
  logic        e_wr;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic int rr_pick(bit [3:0] v, int base, int skip);
    for (int d = 1; d <= 4; d++) begin
      int k;
      k = (base + d) % 4;
      if (v[k] && k != skip) return k;
    end
    return -1;
  endfunction

  function automatic bit [3:0] vvec();
    bit [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = pv[k];
    return v;
  endfunction

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      req_valid[k]           = pv[k];
      req_wr[k]              = pw[k];
      req_address[k*16 +: 16] = pa[k];
      req_wdata[k*16 +: 16]   = pd[k];
    end
  endtask

  // Drive inputs for this cycle and compute what the DUT must show.
  task automatic predict();
    apply();
    #1;
    e_ready = '0; e_addr = '0; e_wdata = '0; e_wr = 1'b0;
    if (m_own >= 0 && pv[m_own]) begin
      e_ready[m_own] = 1'b1;
      e_addr  = pa[m_own];
      e_wdata = pd[m_own];
      e_wr    = pw[m_own];
    end
    e_rv    = m_rv;
    e_rdata = m_rdata;
  endtask

  // Advance the model across the coming clock edge, then wait for it.
  task automatic advance();
    bit [3:0] v;
    int n;
    v = vvec();
    m_rv = '0;
    if (m_own >= 0 && pv[m_own]) begin
      if (pw[m_own]) ref_mem[pa[m_own]] = pd[m_own];
      else if (rstb) begin
        m_rv[m_own] = 1'b1;
        m_rdata     = ref_mem[pa[m_own]];
      end
    end
    if (!rstb) begin
      m_own = -1; m_last = 3; m_cnt = 0; m_rv = '0;
    end else if (m_own >= 0) begin
      if (pv[m_own]) begin
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_last = m_own;
          m_cnt  = 0;
          n = rr_pick(v, m_own, m_own);
          if (n >= 0) m_own = n;
        end
      end else begin
        m_last = m_own;
        m_cnt  = 0;
        m_own  = rr_pick(v, m_own, m_own);
      end
    end else if (v != 0) begin
      m_own = rr_pick(v, m_last, -1);
      m_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0; pw[k] = 1'b0; pa[k] = '0; pd[k] = '0;
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    rstb = 1'b0;
    predict(); advance();
    predict(); advance();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b1; pa[k] = 16'(16'h0A00 + k); end
    rstb = 1'b0;
    predict(); advance();
    predict(); advance();
    rstb = 1'b1;
    predict();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rdata_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rdata_valid: got %b want 0000", rdata_valid); end
    n_cmp++; if (sram_wr !== 1'b0) begin n_fail++; $display("FAIL reset_sram_wr: got %b want 0", sram_wr); end
    n_cmp++; if (sram_address !== 16'h0000) begin n_fail++; $display("FAIL reset_sram_address: got %h want 0000", sram_address); end
    n_cmp++; if (sram_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_sram_wdata: got %h want 0000", sram_wdata); end
    advance();
    predict();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_winner: got %b want 0001", req_ready); end
    advance();
  endtask

  task automatic test_single_read();
    // Seed 0x1234 through the arbiter itself, then restart from reset.
    do_reset();
    pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = 16'h1234; pd[0] = 16'h5A5A;
    predict(); advance();
    predict(); advance();
    pv[0] = 1'b0;
    predict(); advance();
    do_reset();
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 16'h1234;
    predict();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_bubble: got %b want 0000", req_ready); end
    advance();
    predict();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    n_cmp++; if (sram_address !== 16'h1234) begin n_fail++; $display("FAIL single_address: got %h want 1234", sram_address); end
    n_cmp++; if (sram_wr !== 1'b0) begin n_fail++; $display("FAIL single_wr: got %b want 0", sram_wr); end
    advance();
    pv[0] = 1'b0;
    predict();
    n_cmp++; if (rdata_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rdata_valid: got %b want 0001", rdata_valid); end
    n_cmp++; if (rdata !== 16'h5A5A) begin n_fail++; $display("FAIL single_rdata: got %h want 5a5a", rdata); end
    advance();
  endtask

  task automatic test_all_four();
    logic [3:0] want;
    do_reset();
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b1; pw[k] = 1'b0; pa[k] = 16'(k * 256); end
    for (int c = 0; c <= 40; c++) begin
      predict();
      want = (c == 0) ? 4'b0000 : 4'(1 << (((c - 1) / MAXB) % 4));
      n_cmp++;
      if (req_ready !== want) begin
        n_fail++; $display("FAIL all_four_ready c=%0d: got %b want %b", c, req_ready, want);
      end
      advance();
      for (int k = 0; k < 4; k++) if (want[k]) pa[k] = pa[k] + 16'd1;
    end
  endtask

  task automatic test_write_read();
    int  wr_count;
    bit  rv2_seen;
    do_reset();
    wr_count = 0; rv2_seen = 1'b0;
    pv[2] = 1'b1; pw[2] = 1'b1; pa[2] = 16'h0100; pd[2] = 16'hBEEF;
    for (int c = 0; c <= 5; c++) begin
      if (c == 2) begin pv[2] = 1'b0; pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 16'h0100; end
      if (c == 4) pv[1] = 1'b0;
      predict();
      if (sram_wr === 1'b1) wr_count++;
      if (rdata_valid[2] !== 1'b0) rv2_seen = 1'b1;
      if (c == 1) begin
        n_cmp++; if (sram_wr !== 1'b1 || sram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_strobe: got wr=%b data=%h want wr=1 data=beef", sram_wr, sram_wdata); end
      end
      if (c == 3) begin
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wr_then_rd_ready: got %b want 0010", req_ready); end
      end
      if (c == 4) begin
        n_cmp++; if (rdata_valid !== 4'b0010) begin n_fail++; $display("FAIL wr_then_rd_valid: got %b want 0010", rdata_valid); end
        n_cmp++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_then_rd_data: got %h want beef", rdata); end
      end
      advance();
    end
    n_cmp++; if (wr_count != 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_count); end
    n_cmp++; if (rv2_seen) begin n_fail++; $display("FAIL wr_rdata_valid: got set for writer, want never"); end
  endtask

  task automatic test_long_burst();
    int readies;
    do_reset();
    readies = 0;
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 16'h2000;
    for (int c = 0; c <= 22; c++) begin
      predict();
      if (req_ready === 4'b0001) readies++;
      if (c >= 1 && c <= 20) begin
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL burst_ready c=%0d: got %b want 0001", c, req_ready); end
      end
      if (c >= 2 && c <= 21) begin
        n_cmp++; if (rdata_valid !== 4'b0001 || rdata !== e_rdata) begin n_fail++; $display("FAIL burst_rdata c=%0d: got %b/%h want 0001/%h", c, rdata_valid, rdata, e_rdata); end
      end
      advance();
      if (c >= 1) pa[0] = pa[0] + 16'd1;
      if (c == 20) pv[0] = 1'b0;
    end
    n_cmp++; if (readies != 20) begin n_fail++; $display("FAIL burst_count: got %0d want 20", readies); end
  endtask

  task automatic test_drop();
    do_reset();
    pv[3] = 1'b1; pw[3] = 1'b0; pa[3] = 16'h3000;
    predict(); advance();
    predict();
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL drop_owner3: got %b want 1000", req_ready); end
    advance();
    pv[3] = 1'b0; pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 16'h3001;
    predict();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drop_gap: got %b want 0000", req_ready); end
    advance();
    predict();
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL drop_switch: got %b want 0010", req_ready); end
    advance();
    pv[1] = 1'b0;
    predict(); advance();
    predict();
    n_cmp++;
    if (req_ready !== 4'b0000 || sram_wr !== 1'b0 || sram_address !== 16'h0 || sram_wdata !== 16'h0 || rdata_valid !== 4'b0000) begin
      n_fail++; $display("FAIL drop_idle: got rdy=%b wr=%b a=%h d=%h rv=%b want all 0", req_ready, sram_wr, sram_address, sram_wdata, rdata_valid);
    end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b1; pw[k] = 1'b0; pa[k] = 16'(16'h4000 + k); end
    for (int c = 0; c < 4; c++) begin predict(); advance(); end
    predict();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_pre: got %b want 0001", req_ready); end
    rstb = 1'b0;
    advance();
    rstb = 1'b1;
    predict();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rdata_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rdata_valid: got %b want 0000", rdata_valid); end
    advance();
    predict();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_winner: got %b want 0001", req_ready); end
    advance();
  endtask

  task automatic test_random();
    int pcts [3] = '{30, 70, 100};
    bit [3:0] acc_prev;
    int wait_acc [4];
    do_reset();
    acc_prev = '0;
    for (int k = 0; k < 4; k++) wait_acc[k] = 0;
    foreach (pcts[p]) begin
      for (int c = 0; c < 300; c++) begin
        for (int k = 0; k < 4; k++) begin
          if (!pv[k] || acc_prev[k]) begin
            pv[k] = ($urandom_range(99) < pcts[p]);
            pw[k] = 1'($urandom_range(1));
            pa[k] = 16'($urandom_range(15));
            pd[k] = 16'($urandom);
            wait_acc[k] = 0;
          end
        end
        predict();
        n_cmp++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, e_ready); end
        n_cmp++; if (sram_address !== e_addr) begin n_fail++; $display("FAIL rnd_address c=%0d: got %h want %h", c, sram_address, e_addr); end
        n_cmp++; if (sram_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, sram_wdata, e_wdata); end
        n_cmp++; if (sram_wr !== e_wr) begin n_fail++; $display("FAIL rnd_wr c=%0d: got %b want %b", c, sram_wr, e_wr); end
        n_cmp++; if (rdata_valid !== e_rv) begin n_fail++; $display("FAIL rnd_rdata_valid c=%0d: got %b want %b", c, rdata_valid, e_rv); end
        if (e_rv != 0) begin
          n_cmp++; if (rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, e_rdata); end
        end
        for (int k = 0; k < 4; k++) begin
          if (req_ready[k] === 1'b1) begin
            n_cmp++;
            if (wait_acc[k] > 3 * MAXB) begin n_fail++; $display("FAIL rnd_starve port%0d: waited %0d accesses want <= %0d", k, wait_acc[k], 3 * MAXB); end
          end else if (pv[k] && req_ready !== 4'b0000) begin
            wait_acc[k]++;
          end
        end
        acc_prev = e_ready;
        advance();
      end
    end
  endtask

  initial begin
    rstb = 1'b0;
    clear_reqs();
    apply();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_all_four();
    test_write_read();
    test_long_burst();
    test_drop();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
